// File: rtl/mcu_target_router.sv
// Steers the MCU byte channel to one of NUM_TARGETS command targets and muxes replies back.
// Also edge-detects target interrupts into a W1C pending mask that drives the active-low MCU line.

module mcu_tgt_irq (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic clr,
  output logic pend_d
);
  logic irq_q, irq_d, prev_q, prev_d, pend_q;

  // A rising edge in the same cycle as a clear keeps the bit set.
  always_comb begin
    irq_d  = irq;
    prev_d = irq_q;
    pend_d = (irq_q & ~prev_q) | (pend_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q  <= 1'b0;
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      irq_q  <= irq_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end
endmodule

module mcu_target_router #(
  parameter int NUM_TARGETS = 4,
  parameter int TIMEOUT     = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mcu_strobe,
  input  logic                     mcu_start,
  input  logic [7:0]               mcu_din,
  output logic [7:0]               mcu_dout,
  output logic [NUM_TARGETS-1:0]   tgt_strobe,
  output logic                     tgt_start,
  output logic [7:0]               tgt_din,
  input  logic [8*NUM_TARGETS-1:0] tgt_dout,
  input  logic [NUM_TARGETS-1:0]   tgt_int,
  output logic                     int_out_n,
  output logic [7:0]               err_count
);
  localparam int IDW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_FORWARD, S_STATUS, S_DISCARD} state_t;

  state_t                         state_q, state_d;
  logic [IDW-1:0]                 sel_q, sel_d;
  logic [TW-1:0]                  tmo_q, tmo_d;
  logic [7:0]                     err_q, err_d;
  logic [7:0]                     dout_q, dout_d;
  logic [NUM_TARGETS-1:0]         tgt_strobe_q, tgt_strobe_d;
  logic                           tgt_start_q, tgt_start_d;
  logic [7:0]                     tgt_din_q, tgt_din_d;
  logic                           int_out_n_q, int_out_n_d;
  logic [NUM_TARGETS-1:0]         clr, pend_d;
  logic [7:0]                     pend8;
  logic                           id_ok, err_inc;
  logic [NUM_TARGETS-1:0][7:0]    tgt_dout_a;

  assign tgt_dout_a = tgt_dout;
  assign id_ok      = (mcu_din < 8'(NUM_TARGETS));

  mcu_tgt_irq u_irq [NUM_TARGETS-1:0] (
    .clk    (clk),
    .reset  (reset),
    .irq    (tgt_int),
    .clr    (clr),
    .pend_d (pend_d)
  );

  // Selecting a target acknowledges its interrupt; STATUS bytes are a W1C mask.
  always_comb begin
    clr = '0;
    if (mcu_strobe && !mcu_start) begin
      if (state_q == S_SELECT && id_ok)
        clr = NUM_TARGETS'(1) << mcu_din[IDW-1:0];
      else if (state_q == S_STATUS)
        clr = mcu_din[NUM_TARGETS-1:0];
    end
  end

  always_comb begin
    pend8 = '0;
    pend8[NUM_TARGETS-1:0] = pend_d;
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    dout_d       = dout_q;
    tgt_strobe_d = '0;
    tgt_start_d  = 1'b0;
    tgt_din_d    = tgt_din_q;
    int_out_n_d  = ~|pend_d;
    err_inc      = 1'b0;

    if (mcu_strobe) begin
      tmo_d = '0;
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d = S_IDLE;
        tmo_d   = '0;
        dout_d  = 8'h00;
        err_inc = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (mcu_strobe && mcu_start) begin
      state_d = S_SELECT;
      dout_d  = 8'h00;
    end else if (mcu_strobe) begin
      case (state_q)
        S_SELECT: begin
          if (id_ok) begin
            sel_d        = mcu_din[IDW-1:0];
            state_d      = S_FORWARD;
            tgt_strobe_d = NUM_TARGETS'(1) << mcu_din[IDW-1:0];
            tgt_start_d  = 1'b1;
            tgt_din_d    = mcu_din;
          end else if (mcu_din == 8'hFF) begin
            state_d = S_STATUS;
            dout_d  = pend8;
          end else begin
            state_d = S_DISCARD;
            dout_d  = 8'hEE;
            err_inc = 1'b1;
          end
        end
        S_FORWARD: begin
          tgt_strobe_d = NUM_TARGETS'(1) << sel_q;
          tgt_din_d    = mcu_din;
        end
        S_STATUS: dout_d = pend8;
        default: ;
      endcase
    end

    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      tmo_q        <= '0;
      err_q        <= 8'h00;
      dout_q       <= 8'h00;
      tgt_strobe_q <= '0;
      tgt_start_q  <= 1'b0;
      tgt_din_q    <= 8'h00;
      int_out_n_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      dout_q       <= dout_d;
      tgt_strobe_q <= tgt_strobe_d;
      tgt_start_q  <= tgt_start_d;
      tgt_din_q    <= tgt_din_d;
      int_out_n_q  <= int_out_n_d;
    end
  end

  // Reply bytes in FORWARD bypass the register so target timing is untouched.
  assign mcu_dout   = (state_q == S_FORWARD) ? tgt_dout_a[sel_q] : dout_q;
  assign tgt_strobe = tgt_strobe_q;
  assign tgt_start  = tgt_start_q;
  assign tgt_din    = tgt_din_q;
  assign int_out_n  = int_out_n_q;
  assign err_count  = err_q;
endmodule

// File: tb/tb_mcu_target_router.sv
// Directed and randomized byte traffic for mcu_target_router against a transfer-level model.

module tb_mcu_target_router;
  localparam int N = 4;
  localparam int T = 24;
  localparam int M_IDLE = 0, M_SEL = 1, M_FWD = 2, M_ST = 3, M_DIS = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         mcu_strobe = 1'b0;
  logic         mcu_start = 1'b0;
  logic [7:0]   mcu_din = 8'h00;
  logic [7:0]   mcu_dout;
  logic [N-1:0] tgt_strobe;
  logic         tgt_start;
  logic [7:0]   tgt_din;
  logic [8*N-1:0] tgt_dout = '0;
  logic [N-1:0] tgt_int = '0;
  logic         int_out_n;
  logic [7:0]   err_count;

  mcu_target_router #(.NUM_TARGETS(N), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .mcu_strobe(mcu_strobe), .mcu_start(mcu_start),
    .mcu_din(mcu_din), .mcu_dout(mcu_dout), .tgt_strobe(tgt_strobe), .tgt_start(tgt_start),
    .tgt_din(tgt_din), .tgt_dout(tgt_dout), .tgt_int(tgt_int), .int_out_n(int_out_n),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  int         m_mode, m_sel, m_gap;
  logic [N-1:0] m_pend, m_rise, e_stb;
  logic       e_start;
  logic [7:0] m_din, m_dreg, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_dout();
    if (m_mode == M_FWD) return tgt_dout[8*m_sel +: 8];
    return m_dreg;
  endfunction

  task automatic check_all();
    chk("tgt_strobe", 32'(tgt_strobe), 32'(e_stb));
    chk("tgt_start", 32'(tgt_start), 32'(e_start));
    chk("tgt_din", 32'(tgt_din), 32'(m_din));
    chk("mcu_dout", 32'(mcu_dout), 32'(exp_dout()));
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("int_out_n", 32'(int_out_n), 32'(~|m_pend));
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_sel = 0; m_gap = 0; m_pend = '0; m_rise = '0;
    e_stb = '0; e_start = 1'b0; m_din = 8'h00; m_dreg = 8'h00; m_err = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1; tgt_int = '0; mcu_strobe = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_all();
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      e_stb = '0; e_start = 1'b0;
      m_gap++;
      if (m_mode != M_IDLE && m_gap == T) begin
        m_mode = M_IDLE; m_dreg = 8'h00;
        if (m_err != 8'hFF) m_err++;
      end
      check_all();
    end
  endtask

  task automatic send(input logic st, input logic [7:0] d);
    mcu_strobe = 1'b1; mcu_start = st; mcu_din = d;
    @(posedge clk); #1;
    mcu_strobe = 1'b0; mcu_start = 1'b0;
    m_gap = 0; e_stb = '0; e_start = 1'b0;
    if (st) begin
      m_mode = M_SEL; m_dreg = 8'h00;
    end else begin
      case (m_mode)
        M_SEL: begin
          if (d < N) begin
            m_sel = d; m_mode = M_FWD; e_stb = N'(1) << d; e_start = 1'b1; m_din = d;
            m_pend[d] = 1'b0;
          end else if (d == 8'hFF) begin
            m_mode = M_ST; m_dreg = 8'(m_pend);
          end else begin
            m_mode = M_DIS; m_dreg = 8'hEE;
            if (m_err != 8'hFF) m_err++;
          end
        end
        M_FWD: begin e_stb = N'(1) << m_sel; m_din = d; end
        M_ST:  begin m_pend = m_pend & ~d[N-1:0]; m_dreg = 8'(m_pend); end
        default: ;
      endcase
    end
    m_pend = m_pend | m_rise;
    m_rise = '0;
    if (m_mode == M_ST) m_dreg = 8'(m_pend);
    check_all();
  endtask

  // Interrupt must have been low for at least two cycles before raising.
  task automatic raise_int(input int i);
    tgt_int[i] = 1'b1;
    tick(1);
    m_pend[i] = 1'b1;
    tick(1);
  endtask

  task automatic drop_int(input int i);
    tgt_int[i] = 1'b0;
    tick(2);
  endtask

  initial begin
    logic [7:0] d;
    int r, i;
    model_reset();
    tgt_dout = 32'h44_33_22_11;
    do_reset();
    chk("rst_dout", 32'(mcu_dout), 32'h00);
    chk("rst_intn", 32'(int_out_n), 32'h1);

    // basic forward to target 1
    send(1, 8'h5A);
    chk("sel_no_fwd", 32'(tgt_strobe), 32'h0);
    send(0, 8'h01);
    chk("id_start", 32'({tgt_strobe, tgt_start}), 32'({4'b0010, 1'b1}));
    send(0, 8'h05);
    chk("b1_fwd", 32'({tgt_strobe, tgt_start, tgt_din}), 32'({4'b0010, 1'b0, 8'h05}));
    send(0, 8'hAA);
    chk("b2_fwd", 32'({tgt_strobe, tgt_din}), 32'({4'b0010, 8'hAA}));
    tgt_dout[15:8] = 8'hC3; #1;
    chk("reply_pass", 32'(mcu_dout), 32'hC3);

    // interrupt aggregation and status W1C
    raise_int(2);
    chk("int_low", 32'(int_out_n), 32'h0);
    send(1, 8'h00);
    send(0, 8'hFF);
    chk("status_val", 32'(mcu_dout), 32'h04);
    send(0, 8'h04);
    chk("w1c_dout", 32'(mcu_dout), 32'h00);
    tick(1);
    chk("w1c_intn", 32'(int_out_n), 32'h1);
    drop_int(2);

    // bad id
    send(1, 8'h00);
    send(0, 8'h07);
    chk("bad_dout", 32'(mcu_dout), 32'hEE);
    chk("bad_err", 32'(err_count), 32'h01);
    for (int k = 0; k < 3; k++) send(0, 8'(k + 3));

    // timeout boundary then expiry
    send(1, 8'h00);
    send(0, 8'h00);
    tick(T - 1);
    send(0, 8'h22);
    chk("tmo_edge_fwd", 32'(tgt_strobe), 32'h1);
    tick(T);
    chk("tmo_err", 32'(err_count), 32'h02);
    send(0, 8'h33);
    chk("tmo_idle", 32'(tgt_strobe), 32'h0);

    // abort mid-forward by a new start
    send(1, 8'h00); send(0, 8'h00); send(0, 8'h05);
    send(1, 8'h09); send(0, 8'h03); send(0, 8'h07);
    chk("abort_retarget", 32'(tgt_strobe), 32'b1000);

    // rise coinciding with selection keeps the pending bit
    send(1, 8'h00);
    tgt_int[1] = 1'b1;
    tick(1);
    m_rise = 4'b0010;
    send(0, 8'h01);
    chk("set_wins_intn", 32'(int_out_n), 32'h0);
    send(0, 8'h66);
    do_reset();
    chk("midreset", 32'({tgt_strobe, tgt_start, tgt_din, mcu_dout, err_count, int_out_n}), 32'h1);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) == 0) tgt_dout = $urandom;
      r = $urandom_range(0, 19);
      if (r < 4) send(1, 8'($urandom));
      else if (r == 4) begin
        i = $urandom_range(0, N - 1);
        if (tgt_int[i]) drop_int(i); else raise_int(i);
      end else if (r == 5) tick($urandom_range(1, 3));
      else begin
        d = 8'($urandom);
        if (m_mode == M_SEL) begin
          case ($urandom_range(0, 3))
            0, 1: d = 8'($urandom_range(0, N - 1));
            2: d = 8'hFF;
            default: d = 8'($urandom_range(N, 254));
          endcase
        end
        send(0, d);
      end
    end

    // error counter saturation
    tgt_int = '0;
    tick(2);
    for (int k = 0; k < 260; k++) begin
      send(1, 8'($urandom));
      send(0, 8'h80);
    end
    chk("err_sat", 32'(err_count), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
